// File: rtl/spike_motor_decoder.sv
// -----------------------------------------------------------------------------
// spike_motor_decoder
//
// Rate-decoding motor stage downstream of the SNN core. Counts the Left
// (spike_in[0]) and Right (spike_in[1]) spike trains over windows of WIN_LEN
// enabled cycles. From the two window rates it derives a steering decision and
// left/right wheel duties, and drives two glitch-free PWM outputs.
//
// Ports:
//   clk        in   single clock
//   rst        in   asynchronous active-high reset
//   en         in   advances the window and spike counting
//   spike_in   in   [0] Left, [1] Right spikes, one bit per cycle
//   rate_l/r   out  spike counts of the last completed window
//   rate_valid out  one-cycle pulse when the rates update
//   turn       out  00 straight, 01 left, 10 right, 11 stop
//   duty_l/r   out  pending wheel duties
//   pwm_l/r    out  wheel PWM outputs
//
// Configuration macro: SPIKE_MOTOR_PWM_EN
//   defined   : PWM counter, active duty registers and PWM outputs are built.
//   undefined : PWM logic is absent and pwm_l/pwm_r are tied low.
// -----------------------------------------------------------------------------
module spike_motor_decoder #(
    parameter int WIN_LEN   = 256,
    parameter int CNT_W     = 8,
    parameter int PWM_W     = 8,
    parameter int BASE_DUTY = 128,
    parameter int GAIN_SH   = 2,
    parameter int DEADBAND  = 2,
    parameter int MIN_RATE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       spike_in,
    output logic [CNT_W-1:0] rate_l,
    output logic [CNT_W-1:0] rate_r,
    output logic             rate_valid,
    output logic [1:0]       turn,
    output logic [PWM_W-1:0] duty_l,
    output logic [PWM_W-1:0] duty_r,
    output logic             pwm_l,
    output logic             pwm_r
);

    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    // Wide enough that BASE_DUTY +/- (d << GAIN_SH) never overflows before clamping.
    localparam int AW    = PWM_W + CNT_W + GAIN_SH + 2;

    localparam logic [WIN_W-1:0]     WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]       MIN_RATE_V = (CNT_W + 1)'(MIN_RATE);
    localparam logic [CNT_W:0]       DEADBAND_V = (CNT_W + 1)'(DEADBAND);
    localparam logic [PWM_W-1:0]     BASE_V     = PWM_W'(BASE_DUTY);
    localparam logic signed [AW-1:0] BASE_S     = AW'(BASE_DUTY);
    localparam logic signed [AW-1:0] DUTY_MAX_S = {{(AW - PWM_W){1'b0}}, {PWM_W{1'b1}}};

    localparam logic [1:0] TURN_STRAIGHT = 2'b00;
    localparam logic [1:0] TURN_LEFT     = 2'b01;
    localparam logic [1:0] TURN_RIGHT    = 2'b10;
    localparam logic [1:0] TURN_STOP     = 2'b11;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic s);
        if (s && (c != CNT_MAX)) begin
            return c + CNT_W'(1);
        end else begin
            return c;
        end
    endfunction

    function automatic logic [PWM_W-1:0] clamp_duty(input logic signed [AW-1:0] v);
        if (v[AW-1]) begin
            return {PWM_W{1'b0}};
        end else if (v > DUTY_MAX_S) begin
            return {PWM_W{1'b1}};
        end else begin
            return v[PWM_W-1:0];
        end
    endfunction

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WIN_W-1:0]        r_win_cnt;
    logic [CNT_W-1:0]        r_cnt_l;
    logic [CNT_W-1:0]        r_cnt_r;
    logic [CNT_W-1:0]        r_rate_l;
    logic [CNT_W-1:0]        r_rate_r;
    logic                    r_rate_valid;
    logic [1:0]              r_dec;
    logic signed [CNT_W:0]   r_diff;
    logic [1:0]              r_turn;
    logic [PWM_W-1:0]        r_duty_l;
    logic [PWM_W-1:0]        r_duty_r;

    logic                    w_win_end;
    logic signed [CNT_W:0]   w_diff;
    logic [CNT_W:0]          w_sum;
    logic [CNT_W:0]          w_abs;
    logic [1:0]              w_dec;
    logic signed [AW-1:0]    w_d_shift;
    logic [PWM_W-1:0]        w_duty_l;
    logic [PWM_W-1:0]        w_duty_r;

    assign w_win_end = en && (r_win_cnt == WIN_LAST);

    // Window position counter over enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt <= '0;
        end else if (en) begin
            r_win_cnt <= w_win_end ? '0 : r_win_cnt + WIN_W'(1);
        end
    end

    // Saturating spike counters; cleared at window end so the next window starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_l <= '0;
            r_cnt_r <= '0;
        end else if (en) begin
            if (w_win_end) begin
                r_cnt_l <= '0;
                r_cnt_r <= '0;
            end else begin
                r_cnt_l <= sat_inc(r_cnt_l, spike_in[0]);
                r_cnt_r <= sat_inc(r_cnt_r, spike_in[1]);
            end
        end
    end

    // Window rate capture; the spike in the final window cycle is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rate_l     <= '0;
            r_rate_r     <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_rate_valid <= w_win_end;
            if (w_win_end) begin
                r_rate_l <= sat_inc(r_cnt_l, spike_in[0]);
                r_rate_r <= sat_inc(r_cnt_r, spike_in[1]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; COMPUTE and COMMIT run regardless of en.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCUM:   w_next_state = w_win_end ? ST_COMPUTE : ST_ACCUM;
            ST_COMPUTE: w_next_state = ST_COMMIT;
            ST_COMMIT:  w_next_state = ST_ACCUM;
            default:    w_next_state = ST_ACCUM;
        endcase
    end

    // Steering decision from the captured rates.
    always_comb begin
        w_diff = $signed({1'b0, r_rate_l}) - $signed({1'b0, r_rate_r});
        w_sum  = {1'b0, r_rate_l} + {1'b0, r_rate_r};
        w_abs  = w_diff[CNT_W] ? (CNT_W + 1)'(-w_diff) : w_diff;
        w_dec  = TURN_STRAIGHT;
        if (w_sum < MIN_RATE_V) begin
            w_dec = TURN_STOP;
        end else if (w_abs <= DEADBAND_V) begin
            w_dec = TURN_STRAIGHT;
        end else if (w_diff[CNT_W]) begin
            w_dec = TURN_RIGHT;
        end else begin
            w_dec = TURN_LEFT;
        end
    end

    // Decision and difference registered during COMPUTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec  <= TURN_STOP;
            r_diff <= '0;
        end else if (r_state == ST_COMPUTE) begin
            r_dec  <= w_dec;
            r_diff <= w_diff;
        end
    end

    // Wheel duties from the registered decision.
    always_comb begin
        w_d_shift = $signed({{(AW - CNT_W - 1){r_diff[CNT_W]}}, r_diff}) <<< GAIN_SH;
        w_duty_l  = '0;
        w_duty_r  = '0;
        case (r_dec)
            TURN_STOP: begin
                w_duty_l = '0;
                w_duty_r = '0;
            end
            TURN_STRAIGHT: begin
                w_duty_l = BASE_V;
                w_duty_r = BASE_V;
            end
            default: begin
                w_duty_l = clamp_duty(BASE_S - w_d_shift);
                w_duty_r = clamp_duty(BASE_S + w_d_shift);
            end
        endcase
    end

    // Outputs committed in the COMMIT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_turn   <= TURN_STOP;
            r_duty_l <= '0;
            r_duty_r <= '0;
        end else if (r_state == ST_COMMIT) begin
            r_turn   <= r_dec;
            r_duty_l <= w_duty_l;
            r_duty_r <= w_duty_r;
        end
    end

    assign rate_l     = r_rate_l;
    assign rate_r     = r_rate_r;
    assign rate_valid = r_rate_valid;
    assign turn       = r_turn;
    assign duty_l     = r_duty_l;
    assign duty_r     = r_duty_r;

`ifdef SPIKE_MOTOR_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_act_l;
    logic [PWM_W-1:0] r_act_r;
    logic             r_pwm_l;
    logic             r_pwm_r;

    // Free-running PWM; active duty reloads only at the period boundary so pulses never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_act_l   <= '0;
            r_act_r   <= '0;
            r_pwm_l   <= 1'b0;
            r_pwm_r   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (r_pwm_cnt == {PWM_W{1'b1}}) begin
                r_act_l <= r_duty_l;
                r_act_r <= r_duty_r;
            end
            r_pwm_l <= (r_pwm_cnt < r_act_l);
            r_pwm_r <= (r_pwm_cnt < r_act_r);
        end
    end

    assign pwm_l = r_pwm_l;
    assign pwm_r = r_pwm_r;
`else
    assign pwm_l = 1'b0;
    assign pwm_r = 1'b0;
`endif

endmodule

// File: tb/tb_spike_motor_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_motor_decoder
//
// Directed bench for spike_motor_decoder. Instance u_dut uses WIN_LEN=16 for
// the decision / duty / reset scenarios; u_dut_sat uses WIN_LEN=300 for rate
// saturation and duty clamping. PWM expectations follow SPIKE_MOTOR_PWM_EN.
// -----------------------------------------------------------------------------
module tb_spike_motor_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] spike;
    logic       en2;
    logic [1:0] spike2;

    logic [7:0] rate_l_a, rate_r_a, duty_l_a, duty_r_a;
    logic       rv_a, pwm_l_a, pwm_r_a;
    logic [1:0] turn_a;
    logic [7:0] rate_l_b, rate_r_b, duty_l_b, duty_r_b;
    logic       rv_b, pwm_l_b, pwm_r_b;
    logic [1:0] turn_b;

    int n_checks = 0;
    int n_pass   = 0;
    int hl, hr;

`ifdef SPIKE_MOTOR_PWM_EN
    localparam int EXP_PWM_L = 96;
    localparam int EXP_PWM_R = 160;
`else
    localparam int EXP_PWM_L = 0;
    localparam int EXP_PWM_R = 0;
`endif

    spike_motor_decoder #(.WIN_LEN(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike),
        .rate_l(rate_l_a), .rate_r(rate_r_a), .rate_valid(rv_a), .turn(turn_a),
        .duty_l(duty_l_a), .duty_r(duty_r_a), .pwm_l(pwm_l_a), .pwm_r(pwm_r_a)
    );

    spike_motor_decoder #(.WIN_LEN(300)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en2), .spike_in(spike2),
        .rate_l(rate_l_b), .rate_r(rate_r_b), .rate_valid(rv_b), .turn(turn_b),
        .duty_l(duty_l_b), .duty_r(duty_r_b), .pwm_l(pwm_l_b), .pwm_r(pwm_r_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_rate_l"}, int'(rate_l_a), 0);
        check_eq({tag, "_rate_r"}, int'(rate_r_a), 0);
        check_eq({tag, "_rv"},     int'(rv_a),     0);
        check_eq({tag, "_turn"},   int'(turn_a),   3);
        check_eq({tag, "_duty_l"}, int'(duty_l_a), 0);
        check_eq({tag, "_duty_r"}, int'(duty_r_a), 0);
        check_eq({tag, "_pwm_l"},  int'(pwm_l_a),  0);
        check_eq({tag, "_pwm_r"},  int'(pwm_r_a),  0);
    endtask

    // One 16-cycle enabled window, then the T+1 / T+2 / T+3 observations.
    task automatic run_window(input logic [15:0] lm, input logic [15:0] rm,
                              input int el, input int er, input int et,
                              input int edl, input int edr, input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_eq({tag, "_rv_idle"}, int'(rv_a), 0);
            en    = 1'b1;
            spike = {rm[i], lm[i]};
        end
        @(negedge clk);
        en    = 1'b0;
        spike = 2'b00;
        check_eq({tag, "_rv_t1"},   int'(rv_a),     1);
        check_eq({tag, "_rate_l"},  int'(rate_l_a), el);
        check_eq({tag, "_rate_r"},  int'(rate_r_a), er);
        @(negedge clk);
        check_eq({tag, "_rv_t2"},   int'(rv_a),     0);
        @(negedge clk);
        check_eq({tag, "_turn"},    int'(turn_a),   et);
        check_eq({tag, "_duty_l"},  int'(duty_l_a), edl);
        check_eq({tag, "_duty_r"},  int'(duty_r_a), edr);
    endtask

    task automatic count_pwm(input int ncyc, output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cl += int'(pwm_l_a);
            cr += int'(pwm_r_a);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        en2    = 1'b0;
        spike  = 2'b00;
        spike2 = 2'b00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // No spikes: stop with zero duties and silent PWM.
        run_window(16'h0000, 16'h0000, 0, 0, 3, 0, 0, "idle");
        count_pwm(256, hl, hr);
        check_eq("idle_pwm_l", hl, 0);
        check_eq("idle_pwm_r", hr, 0);

        // Left 10, right 2: d=8, shifted 32.
        run_window(16'h03FF, 16'h0003, 10, 2, 1, 96, 160, "left8");
        repeat (300) @(negedge clk);
        count_pwm(256, hl, hr);
        check_eq("left8_pwm_l_high", hl, EXP_PWM_L);
        check_eq("left8_pwm_r_high", hr, EXP_PWM_R);

        run_window(16'h001F, 16'h003F, 5, 6, 0, 128, 128, "dm1");
        run_window(16'h0003, 16'h01FF, 2, 9, 2, 156, 100, "right7");
        run_window(16'h003F, 16'h0007, 6, 3, 1, 116, 140, "dband3");
        run_window(16'h001F, 16'h0007, 5, 3, 0, 128, 128, "dband2");
        run_window(16'h0007, 16'h0000, 3, 0, 3, 0, 0,     "sum3");
        run_window(16'h000F, 16'h0000, 4, 0, 1, 112, 144, "sum4");

        // en at 50%: only the 16 enabled cycles count; right spikes only when disabled.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_eq("tog_rv_idle", int'(rv_a), 0);
            en    = (i % 2 == 1);
            spike = {~en, 1'b1};
        end
        @(negedge clk);
        en    = 1'b0;
        spike = 2'b00;
        check_eq("tog_rv_t1",  int'(rv_a),     1);
        check_eq("tog_rate_l", int'(rate_l_a), 16);
        check_eq("tog_rate_r", int'(rate_r_a), 0);
        repeat (2) @(negedge clk);
        check_eq("tog_turn",   int'(turn_a),   1);
        check_eq("tog_duty_l", int'(duty_l_a), 64);
        check_eq("tog_duty_r", int'(duty_r_a), 192);

        // Asynchronous reset in the middle of a window, sampled before any clock edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en    = 1'b1;
            spike = 2'b11;
        end
        @(negedge clk);
        en    = 1'b0;
        spike = 2'b00;
        #2 rst = 1'b1;
        #1 check_reset("arst");
        @(negedge clk);
        rst = 1'b0;
        run_window(16'h007F, 16'h0000, 7, 0, 1, 100, 156, "post_rst");

        // WIN_LEN=300, left every cycle: rate saturates, duties clamp.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en2    = 1'b1;
            spike2 = 2'b01;
        end
        @(negedge clk);
        en2    = 1'b0;
        spike2 = 2'b00;
        check_eq("sat_rv_t1",  int'(rv_b),     1);
        check_eq("sat_rate_l", int'(rate_l_b), 255);
        check_eq("sat_rate_r", int'(rate_r_b), 0);
        repeat (2) @(negedge clk);
        check_eq("sat_turn",   int'(turn_b),   1);
        check_eq("sat_duty_l", int'(duty_l_b), 0);
        check_eq("sat_duty_r", int'(duty_r_b), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
